int_status_collector: RTL and testbench

- Upstream feeder for the single-bit read-only interrupt status register.
- Captures rising edges on up to EVT_NUM event lines into sticky pending bits, subject to a per-line enable, and drives the register's status-update input.
- Clears on the register's one-cycle read strobe (read-to-clear), then holds status low for a programmable hold-off gap.
- Keeps a saturating event counter and a sticky overflow flag for debug.

---
 rtl/int_status_collector_pkg.sv | 19 +
 rtl/int_status_collector_if.sv | 27 ++
 rtl/int_status_collector_edge_det.sv | 23 ++
 rtl/int_status_collector.sv | 100 ++++++++++
 tb/tb_int_status_collector.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/int_status_collector_pkg.sv
// Shared types and defaults for the interrupt status collector.
// FSM encoding, default widths and the hold-off counter width helper.
package int_status_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int EVT_NUM_DEF = 4;
    localparam int CNT_W_DEF   = 8;

    // Hold-off counter width: clog2(cyc+1), never narrower than one bit.
    function automatic int hold_w(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/int_status_collector_if.sv
// Event/status bundle between the event sources, the collector and the status register.
// Handshake: status_rd is a one-cycle strobe; status_up_data is a level, high exactly while an unread interrupt is presented.
interface int_status_collector_if
    import int_status_pkg::*;
#(
    parameter int EVT_NUM = EVT_NUM_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic [EVT_NUM-1:0] evt_in;
    logic [EVT_NUM-1:0] evt_en;
    logic               status_rd;
    logic               status_up_data;
    logic [EVT_NUM-1:0] evt_pending;
    logic [CNT_W-1:0]   evt_cnt;
    logic               cnt_ovf;
    state_t             fsm_state;

    modport master (
        output evt_in, evt_en, status_rd,
        input  status_up_data, evt_pending, evt_cnt, cnt_ovf, fsm_state
    );

    modport slave (
        input  evt_in, evt_en, status_rd,
        output status_up_data, evt_pending, evt_cnt, cnt_ovf, fsm_state
    );
endinterface

// File: rtl/int_status_collector_edge_det.sv
// Per-line rising-edge detector with capture enable.
// The delayed copy is registered every cycle regardless of enable, so a masked rise is lost, not deferred.
module int_evt_edge_det #(
    parameter int EVT_NUM = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [EVT_NUM-1:0] evt_in,
    input  logic [EVT_NUM-1:0] evt_en,
    output logic [EVT_NUM-1:0] rise
);
    logic [EVT_NUM-1:0] evt_in_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_in_d <= '0;
        end else begin
            evt_in_d <= evt_in;
        end
    end

    assign rise = evt_in & ~evt_in_d & evt_en;
endmodule

// File: rtl/int_status_collector.sv
// Collects event rises into sticky pending bits and drives a read-to-clear status level
// with a programmable hold-off after each clear, plus a saturating debug counter.
module int_status_collector
    import int_status_pkg::*;
#(
    parameter int EVT_NUM     = EVT_NUM_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HOLDOFF_CYC = 2
) (
    input logic                    clk,
    input logic                    rst,
    int_status_collector_if.slave  bus
);
    localparam int HW = hold_w(HOLDOFF_CYC);

    logic [EVT_NUM-1:0] rise;
    logic [EVT_NUM-1:0] pending_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [HW-1:0]      hold_q, hold_d;
    state_t             state_q, state_d;
    logic               any_rise;
    logic               clr;

    int_evt_edge_det #(.EVT_NUM(EVT_NUM)) u_edge (
        .clk    (clk),
        .rst    (rst),
        .evt_in (bus.evt_in),
        .evt_en (bus.evt_en),
        .rise   (rise)
    );

    assign any_rise = |rise;
    // Reads only count while an interrupt is actually being presented.
    assign clr      = bus.status_rd && (state_q == ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~{EVT_NUM{clr}}) | rise;
            if (clr) begin
                cnt_q <= CNT_W'(any_rise);
                ovf_q <= 1'b0;
            end else if (any_rise) begin
                if (&cnt_q) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (bus.status_rd) begin
                    if (HOLDOFF_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                        hold_d  = HW'(HOLDOFF_CYC);
                    end
                end
            end
            HOLDOFF: begin
                hold_d = hold_q - 1'b1;
                if (hold_q == HW'(1)) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign bus.status_up_data = (state_q == ACTIVE);
    assign bus.evt_pending    = pending_q;
    assign bus.evt_cnt        = cnt_q;
    assign bus.cnt_ovf        = ovf_q;
    assign bus.fsm_state      = state_q;
endmodule

// File: tb/tb_int_status_collector.sv
// Bench for int_status_collector: directed scenarios then random traffic, all checked
// against a cycle-count reference model through an expected-output queue.
module tb_int_status_collector;
    import int_status_pkg::*;

    localparam int EVT_NUM = 4;
    localparam int CNT_W   = 2;
    localparam int HOLD    = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int OW      = 1 + EVT_NUM + CNT_W + 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    logic [OW-1:0] exp_q[$];

    // reference model state
    logic [EVT_NUM-1:0] m_prev;
    logic [EVT_NUM-1:0] m_pend;
    int                 m_count;
    bit                 m_active;
    int                 m_wait;

    int_status_collector_if #(.EVT_NUM(EVT_NUM), .CNT_W(CNT_W)) bus ();

    int_status_collector #(
        .EVT_NUM     (EVT_NUM),
        .CNT_W       (CNT_W),
        .HOLDOFF_CYC (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, actual running required finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [OW-1:0] dut_out();
        return {bus.status_up_data, bus.evt_pending, bus.evt_cnt, bus.cnt_ovf};
    endfunction

    task automatic model_reset();
        m_prev   = '0;
        m_pend   = '0;
        m_count  = 0;
        m_active = 1'b0;
        m_wait   = 0;
    endtask

    // driver: apply one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input logic [EVT_NUM-1:0] ein, input logic [EVT_NUM-1:0] een,
                        input logic rd);
        logic [EVT_NUM-1:0] r;
        bit                 clr;
        int                 cv;
        @(negedge clk);
        bus.evt_in    = ein;
        bus.evt_en    = een;
        bus.status_rd = rd;
        r      = ein & ~m_prev & een;
        m_prev = ein;
        clr    = m_active && rd;
        if (m_active) begin
            if (rd) begin
                m_active = 1'b0;
                m_wait   = HOLD;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (m_pend != 0) begin
            m_active = 1'b1;
        end
        if (clr) begin
            m_pend  = r;
            m_count = (r != 0) ? 1 : 0;
        end else begin
            m_pend = m_pend | r;
            if (r != 0) m_count++;
        end
        cv = (m_count > CNT_MAX) ? CNT_MAX : m_count;
        exp_q.push_back({m_active, m_pend, CNT_W'(cv), (m_count > CNT_MAX)});
    endtask

    task automatic idle(input int n, input logic [EVT_NUM-1:0] ein, input logic [EVT_NUM-1:0] een);
        for (int i = 0; i < n; i++) step(ein, een, 1'b0);
    endtask

    // asynchronous reset between edges; outputs must clear without a clock edge
    task automatic async_reset(input logic [EVT_NUM-1:0] ein_hold);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (dut_out() !== '0 || bus.fsm_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset: actual out=%h state=%0d required out=0 state=0",
                     dut_out(), bus.fsm_state);
        end
        model_reset();
        bus.evt_in    = ein_hold;
        bus.status_rd = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [OW-1:0] exp;
        #2;
        cyc++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (dut_out() !== exp) begin
                errors++;
                $display("FAIL out@cyc%0d: actual st=%0b pend=%h cnt=%0d ovf=%0b required st=%0b pend=%h cnt=%0d ovf=%0b",
                         cyc, dut_out() >> (OW-1), bus.evt_pending, bus.evt_cnt, bus.cnt_ovf,
                         exp[OW-1], exp[OW-2 -: EVT_NUM], exp[CNT_W:1], exp[0]);
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        bus.evt_in    = '0;
        bus.evt_en    = '0;
        bus.status_rd = 1'b0;
        rst           = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_out() !== '0) begin
            errors++;
            $display("FAIL reset_state: actual %h required 0", dut_out());
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        // single event, read, hold-off
        idle(4, 4'h0, 4'hF);
        step(4'h1, 4'hF, 1'b0);
        idle(4, 4'h1, 4'hF);
        step(4'h1, 4'hF, 1'b1);
        idle(4, 4'h1, 4'hF);
        step(4'h0, 4'hF, 1'b1);   // read in IDLE is ignored

        // masking
        step(4'h3, 4'h2, 1'b0);
        idle(2, 4'h3, 4'h2);
        step(4'h0, 4'h0, 1'b0);
        step(4'h3, 4'h0, 1'b0);
        idle(2, 4'h3, 4'h0);
        step(4'h0, 4'hF, 1'b1);
        idle(4, 4'h0, 4'hF);

        // set/clear collision
        step(4'h1, 4'hF, 1'b0);
        idle(2, 4'h1, 4'hF);
        step(4'h5, 4'hF, 1'b1);
        step(4'h5, 4'hF, 1'b1);   // read in HOLDOFF is ignored
        idle(4, 4'h5, 4'hF);
        step(4'h0, 4'hF, 1'b1);
        idle(4, 4'h0, 4'hF);

        // saturation: five rises on line 0
        for (int i = 0; i < 5; i++) begin
            step(4'h1, 4'h1, 1'b0);
            step(4'h0, 4'h1, 1'b0);
        end
        step(4'h0, 4'h1, 1'b1);
        idle(4, 4'h0, 4'hF);

        // mid-hold-off reset with line 3 pending, line 3 still high at release
        step(4'h1, 4'hF, 1'b0);
        idle(2, 4'h1, 4'hF);
        step(4'h1, 4'hF, 1'b1);
        step(4'h9, 4'hF, 1'b0);
        async_reset(4'h8);
        idle(5, 4'h8, 4'hF);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(EVT_NUM'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? EVT_NUM'($urandom_range(0, 15)) : 4'hF,
                 ($urandom_range(0, 3) == 0));
        end

        // drain
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
